// File: rtl/cu_pkg.sv
// Shared constants for the stack control unit: default parameters, one-hot
// FSM encodings, opcodes and stack-operation encoding.
package cu_pkg;

  localparam int unsigned DATA_RANGE_DEF    = 8;
  localparam int unsigned INST_RANGE_DEF    = 12;
  localparam int unsigned OP_CODE_RANGE_DEF = 4;
  localparam int unsigned STACK_DEPTH_DEF   = 16;

  localparam logic [3:0] ST_FETCH  = 4'b0001;
  localparam logic [3:0] ST_DECODE = 4'b0010;
  localparam logic [3:0] ST_EXEC   = 4'b0100;
  localparam logic [3:0] ST_HALT   = 4'b1000;

  localparam logic [3:0] OP_PUSHC = 4'b0000;
  localparam logic [3:0] OP_POP   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_JZ    = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  // ADD/SUB are expressed as "pop one, overwrite the new top" (POP_REPL).
  typedef enum logic [1:0] {
    STK_NONE     = 2'd0,
    STK_PUSH     = 2'd1,
    STK_POP      = 2'd2,
    STK_POP_REPL = 2'd3
  } stk_op_e;

  function automatic logic [1:0] op_pops(input logic [3:0] opc);
    case (opc)
      OP_POP, OP_JZ:  op_pops = 2'd1;
      OP_ADD, OP_SUB: op_pops = 2'd2;
      default:        op_pops = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] op_pushes(input logic [3:0] opc);
    case (opc)
      OP_PUSHC, OP_ADD, OP_SUB: op_pushes = 2'd1;
      default:                  op_pushes = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cu_stack.sv
// Register-array stack with push, pop and pop-then-replace-top; keeps a
// registered copy of the top entry so 'top' is a flop output.
module cu_stack
  import cu_pkg::*;
#(
  parameter  int unsigned DATA_RANGE  = DATA_RANGE_DEF,
  parameter  int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  localparam int unsigned IW          = $clog2(STACK_DEPTH),
  localparam int unsigned SPW         = IW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  stk_op_e               op,
  input  logic [DATA_RANGE-1:0] wdata,
  output logic [SPW-1:0]        sp,
  output logic [DATA_RANGE-1:0] top,
  output logic [DATA_RANGE-1:0] second_c
);

  logic [DATA_RANGE-1:0] mem [STACK_DEPTH];
  logic [IW-1:0]         idx_below;

  assign idx_below = IW'(sp - SPW'(2));
  assign second_c  = (sp >= SPW'(2)) ? mem[idx_below] : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      case (op)
        STK_PUSH:     mem[sp[IW-1:0]] <= wdata;
        STK_POP_REPL: mem[idx_below]  <= wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      top <= '0;
    end else begin
      case (op)
        STK_PUSH: begin
          sp  <= sp + SPW'(1);
          top <= wdata;
        end
        STK_POP: begin
          sp  <= sp - SPW'(1);
          top <= second_c;
        end
        STK_POP_REPL: begin
          sp  <= sp - SPW'(1);
          top <= wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stack_control_unit.sv
// Fetch/decode/execute controller for a small stack machine.
// Optional CU_STACK_TRAP_EN: stack faults set err and halt instead of acting as NOP.
module stack_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned DATA_RANGE    = DATA_RANGE_DEF,
  parameter int unsigned INST_RANGE    = INST_RANGE_DEF,
  parameter int unsigned OP_CODE_RANGE = OP_CODE_RANGE_DEF,
  parameter int unsigned STACK_DEPTH   = STACK_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_RANGE-1:0]         init_PC,
  output logic [DATA_RANGE-1:0]         imem_addr,
  output logic                          imem_rd,
  input  logic [INST_RANGE-1:0]         imem_data,
  input  logic                          imem_valid,
  output logic [DATA_RANGE-1:0]         pc,
  output logic [DATA_RANGE-1:0]         top,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          halted,
  output logic                          err
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  logic [3:0]            state, state_nxt;
  logic [INST_RANGE-1:0] ir, ir_nxt;
  logic [DATA_RANGE-1:0] pc_nxt, pc_inc, operand, second, stk_wdata;
  logic                  halted_nxt, fault_q, fault_nxt, fault_c;
  logic [3:0]            opc;
  logic [SPW:0]          sp_ext, sp_after;
  stk_op_e               stk_op;

  assign opc       = 4'(ir[INST_RANGE-1 -: OP_CODE_RANGE]);
  assign operand   = ir[DATA_RANGE-1:0];
  assign pc_inc    = pc + DATA_RANGE'(1);
  assign imem_addr = pc;
  assign imem_rd   = (state == ST_FETCH);

  // Fault check on the stack depth the instruction will see; underflow wraps sp_after high.
  assign sp_ext   = {1'b0, sp};
  assign sp_after = sp_ext + (SPW+1)'(op_pushes(opc)) - (SPW+1)'(op_pops(opc));
  assign fault_c  = (sp_ext < (SPW+1)'(op_pops(opc))) ||
                    (sp_after > (SPW+1)'(STACK_DEPTH));

`ifdef CU_STACK_TRAP_EN
  logic err_nxt;
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= err_nxt;
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc      <= init_PC;
      ir      <= '0;
      halted  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      ir      <= ir_nxt;
      halted  <= halted_nxt;
      fault_q <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    ir_nxt     = ir;
    halted_nxt = halted;
    fault_nxt  = fault_q;
    stk_op     = STK_NONE;
    stk_wdata  = operand;
`ifdef CU_STACK_TRAP_EN
    err_nxt    = err;
`endif
    case (state)
      ST_FETCH: begin
        if (imem_valid) begin
          ir_nxt    = imem_data;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: begin
        fault_nxt = fault_c;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc_inc;
        if (fault_q) begin
`ifdef CU_STACK_TRAP_EN
          err_nxt    = 1'b1;
          halted_nxt = 1'b1;
          pc_nxt     = pc;
          state_nxt  = ST_HALT;
`endif
        end else begin
          case (opc)
            OP_PUSHC: stk_op = STK_PUSH;
            OP_POP:   stk_op = STK_POP;
            OP_ADD: begin
              stk_op    = STK_POP_REPL;
              stk_wdata = second + top;
            end
            OP_SUB: begin
              stk_op    = STK_POP_REPL;
              stk_wdata = second - top;
            end
            OP_JMP:   pc_nxt = operand;
            OP_JZ: begin
              stk_op = STK_POP;
              pc_nxt = (top == '0) ? operand : pc_inc;
            end
            OP_HALT: begin
              halted_nxt = 1'b1;
              state_nxt  = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: ;
      default: state_nxt = ST_FETCH;
    endcase
  end

  cu_stack #(
    .DATA_RANGE  (DATA_RANGE),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .op       (stk_op),
    .wdata    (stk_wdata),
    .sp       (sp),
    .top      (top),
    .second_c (second)
  );

endmodule

// File: tb/tb_stack_control_unit.sv
// Scoreboard bench for stack_control_unit: a reference stack model predicts
// each retirement; a negedge monitor pops and compares when the DUT retires.
module tb_stack_control_unit;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  init_PC = 8'h00;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [11:0] imem_data = 12'h000;
  logic        imem_valid = 1'b0;
  logic [7:0]  pc, top;
  logic [4:0]  sp;
  logic        halted, err;

  always #5 clk = ~clk;

  stack_control_unit dut (
    .clk        (clk),
    .rst        (rst),
    .init_PC    (init_PC),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .pc         (pc),
    .top        (top),
    .sp         (sp),
    .halted     (halted),
    .err        (err)
  );

  typedef struct {
    logic [7:0] pc;
    logic [4:0] sp;
    logic [7:0] top;
    logic       halted;
    logic       err;
    int         issue_cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         mon_en  = 1'b0;
  logic       prev_rd = 1'b0;
  logic       prev_halt = 1'b0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_halt, m_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_top();
    return (m_stk.size() == 0) ? 8'h00 : m_stk[$];
  endfunction

  // Reference behaviour of one instruction.
  task automatic model_step(input logic [3:0] opc, input logic [7:0] opr);
    int pops, pushes;
    logic [7:0] a, b, x;
    pops   = 0;
    pushes = 0;
    case (opc)
      4'h0: pushes = 1;
      4'h1, 4'h5: pops = 1;
      4'h2, 4'h3: begin pops = 2; pushes = 1; end
      default: ;
    endcase
    if (m_stk.size() < pops || m_stk.size() - pops + pushes > DEPTH) begin
`ifdef CU_STACK_TRAP_EN
      m_err  = 1'b1;
      m_halt = 1'b1;
`else
      m_pc = m_pc + 8'd1;
`endif
    end else begin
      case (opc)
        4'h0: begin m_stk.push_back(opr); m_pc = m_pc + 8'd1; end
        4'h1: begin x = m_stk.pop_back(); m_pc = m_pc + 8'd1; end
        4'h2: begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(8'(a + b)); m_pc = m_pc + 8'd1; end
        4'h3: begin b = m_stk.pop_back(); a = m_stk.pop_back(); m_stk.push_back(8'(a - b)); m_pc = m_pc + 8'd1; end
        4'h4: m_pc = opr;
        4'h5: begin x = m_stk.pop_back(); m_pc = (x == 8'h00) ? opr : m_pc + 8'd1; end
        4'hF: begin m_halt = 1'b1; m_pc = m_pc + 8'd1; end
        default: m_pc = m_pc + 8'd1;
      endcase
    end
  endtask

  task automatic do_reset(input logic [7:0] start_pc);
    mon_en     = 1'b0;
    sb.delete();
    rst        = 1'b1;
    init_PC    = start_pc;
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_pc   = start_pc;
    m_stk.delete();
    m_halt = 1'b0;
    m_err  = 1'b0;
    chk("rst_pc", pc, start_pc);
    chk("rst_addr", imem_addr, start_pc);
    chk("rst_sp", sp, 0);
    chk("rst_top", top, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_rd", imem_rd, 1);
    mon_en = 1'b1;
  endtask

  // Present one instruction once the previous one has retired.
  task automatic issue(input logic [3:0] opc, input logic [7:0] opr, input int stall, input bit junk);
    int         w;
    bit         to;
    logic [7:0] pc0;
    logic [4:0] sp0;
    exp_t       e;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((sb.size() != 0 || imem_rd !== 1'b1) && w < 60);
    to = (w >= 60);
    chk("issue_wait_timeout", to, 0);
    if (to) return;
    pc0 = m_pc;
    sp0 = 5'(m_stk.size());
    imem_valid = 1'b0;
    for (int i = 0; i < stall; i++) begin
      chk("stall_rd", imem_rd, 1);
      chk("stall_pc", pc, pc0);
      chk("stall_sp", sp, sp0);
      @(negedge clk);
    end
    imem_data  = {opc, opr};
    imem_valid = 1'b1;
    model_step(opc, opr);
    e.pc        = m_pc;
    e.sp        = 5'(m_stk.size());
    e.top       = m_top();
    e.halted    = m_halt;
    e.err       = m_err;
    e.issue_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    if (junk) begin
      imem_data = {4'h0, 8'hAA};
      repeat (2) @(negedge clk);
    end
    imem_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic hold_halt();
    imem_data  = {4'h0, 8'h55};
    imem_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("halt_rd", imem_rd, 0);
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, m_pc);
      chk("halt_sp", sp, m_stk.size());
    end
    imem_valid = 1'b0;
  endtask

  // Retirement monitor: FETCH re-entry (imem_rd rising) or halted rising.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !rst && ((imem_rd && !prev_rd) || (halted && !prev_halt))) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ret_pc", pc, e.pc);
        chk("ret_sp", sp, e.sp);
        chk("ret_top", top, e.top);
        chk("ret_halted", halted, e.halted);
        chk("ret_err", err, e.err);
        chk("ret_latency", cyc - e.issue_cyc, 3);
      end
    end
    prev_rd   = imem_rd;
    prev_halt = halted;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Arithmetic, jumps, stall, ignored valid outside FETCH, empty-stack pop.
    do_reset(8'h10);
    issue(4'h0, 8'd5, 0, 0);
    issue(4'h0, 8'd3, 0, 0);
    issue(4'h2, 8'h00, 0, 0);
    drain();
    chk("add_top", top, 8'd8);
    chk("add_pc", pc, 8'h13);
    issue(4'h0, 8'd2, 0, 0);
    issue(4'h0, 8'd7, 0, 0);
    issue(4'h3, 8'h00, 0, 0);
    drain();
    chk("sub_top", top, 8'hFB);
    chk("sub_sp", sp, 2);
    issue(4'h2, 8'h00, 0, 0);
    issue(4'h4, 8'h80, 0, 1);
    issue(4'h1, 8'h00, 0, 0);
    issue(4'h0, 8'h00, 4, 0);
    issue(4'h5, 8'h40, 0, 0);
    drain();
    chk("jz_pc", pc, 8'h40);
    chk("jz_sp", sp, 0);
    issue(4'h0, 8'h01, 0, 0);
    issue(4'h5, 8'h90, 0, 0);
    issue(4'h1, 8'h00, 0, 0);
    drain();
`ifdef CU_STACK_TRAP_EN
    hold_halt();
`else
    issue(4'h0, 8'h33, 0, 0);
    drain();
`endif

    // PC wrap and overflow on the 17th push.
    do_reset(8'hFF);
    issue(4'h6, 8'h00, 0, 0);
    drain();
    chk("wrap_pc", pc, 8'h00);
    for (int i = 0; i < 17; i++) issue(4'h0, 8'(i + 1), 0, 0);
    drain();
    chk("ovf_sp", sp, 16);

    // Reset while EXEC is in progress, then the HALT opcode.
    do_reset(8'h20);
    issue(4'h0, 8'h11, 0, 0);
    issue(4'h0, 8'h22, 0, 0);
    issue(4'h0, 8'h33, 0, 0);
    @(negedge clk);
    mon_en = 1'b0;
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pc", pc, 8'h20);
    chk("midrst_sp", sp, 0);
    chk("midrst_top", top, 0);
    chk("midrst_halted", halted, 0);
    chk("midrst_err", err, 0);
    chk("midrst_rd", imem_rd, 1);
    do_reset(8'h20);
    issue(4'h0, 8'h44, 0, 0);
    issue(4'hF, 8'h00, 0, 0);
    drain();
    hold_halt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_control_unit.md
STACK_CONTROL_UNIT -- requirements
Module: stack_control_unit

Interface
REQ-001 SHALL have parameter DATA_RANGE, default 8, meaning data, PC and stack-entry width.
REQ-002 SHALL have parameter INST_RANGE, default 12, meaning instruction width.
REQ-003 SHALL have parameter OP_CODE_RANGE, default 4, meaning opcode width, taken from IR[INST_RANGE-1:INST_RANGE-OP_CODE_RANGE].
REQ-004 SHALL have parameter STACK_DEPTH, default 16, meaning number of stack entries (power of two, at least 2).
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have ports: init_PC  in  DATA_RANGE  start address, sampled during reset.
REQ-007 SHALL have ports: imem_addr  out  DATA_RANGE  fetch address; imem_rd  out  1  fetch request; imem_data  in  INST_RANGE  instruction word; imem_valid  in  1  imem_data valid.
REQ-008 SHALL have ports: pc  out  DATA_RANGE; top  out  DATA_RANGE  top of stack, 0 when empty; sp  out  $clog2(STACK_DEPTH)+1  entry count; halted  out  1; err  out  1  sticky stack fault.

Function
REQ-009 SHALL run a one-hot FSM with states FETCH, DECODE, EXEC and HALT.
REQ-010 In FETCH: imem_rd=1 and imem_addr=pc; on imem_valid=1, IR<=imem_data and go to DECODE; otherwise stay in FETCH with no other state change.
REQ-011 DECODE SHALL always go to EXEC, with the fault check precomputed: underflow if sp < pops, overflow if the result sp > STACK_DEPTH.
REQ-012 EXEC SHALL retire the instruction, update pc and go to FETCH; with zero-wait memory, latency is 3 cycles per instruction.
REQ-013 Opcodes, with operand = IR[DATA_RANGE-1:0]:
- 0000 PUSHC: push operand.
- 0001 POP: discard top.
- 0010 ADD: pop b, pop a, push a+b.
- 0011 SUB: pop b, pop a, push a-b.
- 0100 JMP: pc<=operand.
- 0101 JZ: pop x; pc<=operand if x==0, else pc+1.
- 1111 HALT: go to HALT.
- All other opcodes: NOP.
REQ-014 Arithmetic SHALL be modulo 2^DATA_RANGE; there are no carry or overflow flags.
REQ-015 Non-jump instructions SHALL set pc<=pc+1, wrapping from 2^DATA_RANGE-1 to 0.
REQ-016 An instruction with a fault SHALL NOT modify the stack; pc behaviour follows REQ-023/REQ-024.
REQ-017 HALT state SHALL be absorbing until rst: halted=1, imem_rd=0, no state change.
REQ-018 imem_valid while not in FETCH SHALL be ignored.
REQ-019 rst SHALL take priority over all activity, including a FETCH wait or EXEC in progress.

Reset
REQ-020 On rst=1 at a clk edge: pc<=init_PC, state<=FETCH, sp<=0, IR<=0, halted<=0, err<=0.
REQ-021 While sp==0, top SHALL read 0.
REQ-022 Stack contents SHALL NOT be reset.

Configuration
REQ-023 With macro CU_STACK_TRAP_EN defined: a fault sets err<=1, leaves pc unchanged and enters HALT in the EXEC cycle.
REQ-024 Without CU_STACK_TRAP_EN: a faulting instruction executes as a NOP (pc+1, continue) and err is tied to 0.

Structure
REQ-025 Package cu_pkg SHALL hold the opcode constants, the one-hot state encodings (FETCH=4'b0001, DECODE=4'b0010, EXEC=4'b0100, HALT=4'b1000) and the default parameter values.
REQ-026 Stack storage SHALL be the sub-module cu_stack (register array with push/pop/replace-top and sp, top outputs); the FSM and PC stay in stack_control_unit.

Verification
REQ-027 Reset with init_PC=8'h10, then PUSHC 5, PUSHC 3, ADD, zero-wait -> top=8, sp=1, pc=8'h13 after 9 cycles.
REQ-028 PUSHC 2, PUSHC 7, SUB -> top=8'hFB, sp=1.
REQ-029 imem_valid held low 4 cycles in FETCH -> pc, sp and state unchanged, imem_rd held 1; the instruction completes 3 cycles after valid.
REQ-030 sp=0 then POP:
- with CU_STACK_TRAP_EN -> err=1, halted=1, pc unchanged;
- without it -> err=0, pc+1, execution continues.
REQ-031 Stack fault by overflow: 17 consecutive PUSHC with STACK_DEPTH=16 -> the 17th faults per REQ-023/REQ-024; sp stays 16.
REQ-032 PUSHC 0, JZ 8'h40 -> pc=8'h40, sp=0. Separately, pc=8'hFF executing NOP -> pc=8'h00. rst asserted in the middle of EXEC -> REQ-020 values on the next cycle.
